fetch_unit: RTL and testbench

Instruction-fetch stage that owns the program counter and consumes the 8-bit branch target produced by the branch-target formatter. It issues sequential reads to a synchronous instruction memory (1-cycle read latency) and buffers the returned words in a 2-entry queue. It presents each word to decode with a valid/ready handshake. Taken branches redirect the PC and flush all in-flight work; a halt request drains the stage and parks it.

---
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. It owns the PC, issues sequential reads
// to a 1-cycle-latency instruction memory, buffers the returned words in a
// 2-entry queue and hands them to decode over a valid/ready handshake. Taken
// branches redirect and flush; halt drains the stage and parks it.
module fetch_unit #(
    parameter int                  PC_WIDTH    = 8,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_en,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    input  logic                   halt,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [PC_WIDTH-1:0]    instr_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic                   halted
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
    } entry_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                pending_q, pending_d;
    logic [PC_WIDTH-1:0] pending_pc_q, pending_pc_d;
    logic [1:0]          count_q, count_d;
    entry_t              q0_q, q0_d;   // queue head
    entry_t              q1_q, q1_d;   // second entry

    logic       pop;
    logic       issue;
    logic       write;
    logic [2:0] occupancy;
    logic [1:0] wr_slot;

    // Handshake and issue decision: a read may only go out if, after this
    // cycle's pop, the queue plus the outstanding read still leave a free slot.
    always_comb begin
        pop       = (count_q != 2'd0) && instr_ready;
        occupancy = {1'b0, count_q} + {2'b00, pending_q} - {2'b00, pop};
        issue     = (state_q == ST_RUN) && !halt && !branch_taken && (occupancy < 3'd2);
        write     = pending_q && !branch_taken;
        wr_slot   = count_q - {1'b0, pop};
    end

    // Next-state logic for PC, outstanding read, queue and FSM.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pending_d    = 1'b0;
        pending_pc_d = pending_pc_q;
        count_d      = count_q;
        q0_d         = q0_q;
        q1_d         = q1_q;

        if (branch_taken) begin
            // Redirect wins over everything; a same-cycle pop is still taken
            // by decode, but the queue and the arriving response are dropped.
            fetch_pc_d = branch_target;
            count_d    = 2'd0;
            state_d    = ST_RUN;
        end else begin
            if (issue) begin
                fetch_pc_d   = fetch_pc_q + PC_WIDTH'(1);
                pending_d    = 1'b1;
                pending_pc_d = fetch_pc_q;
            end

            if (pop) begin
                q0_d = q1_q;
            end
            if (write) begin
                if (wr_slot == 2'd0) begin
                    q0_d = '{pc: pending_pc_q, instr: imem_rdata};
                end else begin
                    q1_d = '{pc: pending_pc_q, instr: imem_rdata};
                end
            end
            count_d = count_q - {1'b0, pop} + {1'b0, write};

            unique case (state_q)
                ST_RUN:    if (halt) state_d = ST_DRAIN;
                ST_DRAIN:  if (count_d == 2'd0 && !pending_d) state_d = ST_HALTED;
                ST_HALTED: state_d = ST_HALTED;
                default:   state_d = ST_RUN;
            endcase
        end
    end

    // State registers; asynchronous reset returns the whole stage to idle.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the queue storage is reset too, because instr_out/instr_pc
        // are defined to read zero out of reset.
        if (rst) begin
            state_q      <= ST_RUN;
            fetch_pc_q   <= RESET_PC;
            pending_q    <= 1'b0;
            pending_pc_q <= '0;
            count_q      <= 2'd0;
            q0_q         <= '0;
            q1_q         <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pending_q    <= pending_d;
            pending_pc_q <= pending_pc_d;
            count_q      <= count_d;
            q0_q         <= q0_d;
            q1_q         <= q1_d;
        end
    end

    // Outputs: memory request and queue head.
    always_comb begin
        imem_en     = issue && !rst;
        imem_addr   = fetch_pc_q;
        instr_out   = q0_q.instr;
        instr_pc    = q0_q.pc;
        instr_valid = (count_q != 2'd0);
        halted      = (state_q == ST_HALTED);
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. A behavioural memory returns
// a word derived from its address; expected PCs are queued by each scenario
// and compared whenever decode accepts a word.
module tb_fetch_unit;

    localparam int             PW  = 8;
    localparam int             IW  = 32;
    localparam logic [PW-1:0]  RPC = 8'h10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          imem_en;
    logic [PW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata = '0;
    logic          branch_taken = 1'b0;
    logic [PW-1:0] branch_target = '0;
    logic          halt = 1'b0;
    logic [IW-1:0] instr_out;
    logic [PW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready = 1'b1;
    logic          halted;

    int            total = 0;
    int            bad   = 0;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] mon_pc;

    fetch_unit #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .branch_taken(branch_taken),
        .branch_target(branch_target), .halt(halt), .instr_out(instr_out),
        .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a);
        return {a, ~a, 8'h5A, a};
    endfunction

    // Synchronous instruction memory, one cycle of read latency.
    always @(posedge clk) if (imem_en) imem_rdata <= mem_word(imem_addr);

    // Scoreboard: every accepted word must be the next expected one.
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL accept_unexpected: got pc=%h, required no delivery", instr_pc);
            end else begin
                mon_pc = exp_q.pop_front();
                if (instr_pc !== mon_pc || instr_out !== mem_word(mon_pc)) begin
                    bad++;
                    $display("FAIL accept_order: got pc=%h instr=%h, required pc=%h instr=%h",
                             instr_pc, instr_out, mon_pc, mem_word(mon_pc));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; instr_ready = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        total++;
        if (instr_valid !== 1'b0 || instr_out !== '0 || instr_pc !== '0 || halted !== 1'b0 || imem_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: got valid=%b out=%h pc=%h halted=%b en=%b, required all zero",
                     instr_valid, instr_out, instr_pc, halted, imem_en);
        end
        for (int i = 0; i < 8; i++) exp_q.push_back(RPC + PW'(i));
        for (int c = 0; c < 10; c++) begin
            tick();
            if (c == 0) rst = 1'b0;
            @(negedge clk);
            if (c < 3) begin
                total++;
                if (imem_en !== 1'b1 || imem_addr !== RPC + PW'(c)) begin
                    bad++;
                    $display("FAIL reset_issue c%0d: got en=%b addr=%h, required en=1 addr=%h",
                             c, imem_en, imem_addr, RPC + PW'(c));
                end
                total++;
                if (instr_valid !== (c == 2)) begin
                    bad++;
                    $display("FAIL reset_latency c%0d: got valid=%b, required %b", c, instr_valid, c == 2);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 5; c++) begin
            tick();
            instr_ready = 1'b0;
            @(negedge clk);
            total++;
            if (imem_en !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 8'h18) begin
                bad++;
                $display("FAIL backpressure_hold c%0d: got en=%b valid=%b pc=%h, required en=0 valid=1 pc=18",
                         c, imem_en, instr_valid, instr_pc);
            end
        end
        for (int i = 0; i < 6; i++) exp_q.push_back(8'h18 + PW'(i));
        for (int c = 0; c < 6; c++) begin
            tick();
            instr_ready = 1'b1;
        end
    endtask

    task automatic test_branch();
        exp_q.push_back(8'h1E);
        tick();
        branch_taken = 1'b1; branch_target = 8'h40; instr_ready = 1'b1;
        @(negedge clk);
        total++;
        if (imem_en !== 1'b0) begin
            bad++;
            $display("FAIL branch_no_issue: got en=%b, required 0", imem_en);
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h40 + PW'(i));
        for (int c = 0; c < 6; c++) begin
            tick();
            branch_taken = 1'b0;
            @(negedge clk);
            if (c == 0) begin
                total++;
                if (instr_valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 8'h40) begin
                    bad++;
                    $display("FAIL branch_redirect: got valid=%b en=%b addr=%h, required valid=0 en=1 addr=40",
                             instr_valid, imem_en, imem_addr);
                end
            end else if (c < 3) begin
                total++;
                if (instr_valid !== (c == 2)) begin
                    bad++;
                    $display("FAIL branch_latency c%0d: got valid=%b, required %b", c, instr_valid, c == 2);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [PW-1:0] a;
        tick();
        instr_ready = 1'b0;
        tick();
        branch_taken = 1'b1; branch_target = 8'hFE;
        exp_q.push_back(8'hFE); exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        a = 8'hFE;
        for (int c = 0; c < 6; c++) begin
            tick();
            branch_taken = 1'b0; instr_ready = 1'b1;
            @(negedge clk);
            if (c < 3) begin
                total++;
                if (imem_en !== 1'b1 || imem_addr !== a) begin
                    bad++;
                    $display("FAIL wrap_addr c%0d: got en=%b addr=%h, required en=1 addr=%h", c, imem_en, imem_addr, a);
                end
                a = a + 8'h01;
            end
        end
    endtask

    task automatic test_halt();
        exp_q.push_back(8'h02); exp_q.push_back(8'h03);
        for (int c = 0; c < 6; c++) begin
            tick();
            halt = (c < 4);
            instr_ready = 1'b1;
            @(negedge clk);
            total++;
            if (imem_en !== 1'b0 || halted !== (c >= 2)) begin
                bad++;
                $display("FAIL halt_drain c%0d: got en=%b halted=%b, required en=0 halted=%b", c, imem_en, halted, c >= 2);
            end
        end
        tick();
        branch_taken = 1'b1; branch_target = 8'h08;
        for (int i = 0; i < 3; i++) exp_q.push_back(8'h08 + PW'(i));
        for (int c = 0; c < 5; c++) begin
            tick();
            branch_taken = 1'b0;
            @(negedge clk);
            if (c == 0) begin
                total++;
                if (halted !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 8'h08) begin
                    bad++;
                    $display("FAIL halt_resume: got halted=%b en=%b addr=%h, required halted=0 en=1 addr=08",
                             halted, imem_en, imem_addr);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        tick();
        instr_ready = 1'b0;
        @(negedge clk);
        total++;
        if (instr_valid !== 1'b1) begin
            bad++;
            $display("FAIL midreset_pre: got valid=%b, required 1", instr_valid);
        end
        tick();
        rst = 1'b1;
        #1;
        total++;
        if (instr_valid !== 1'b0 || imem_en !== 1'b0) begin
            bad++;
            $display("FAIL midreset_async: got valid=%b en=%b, required valid=0 en=0", instr_valid, imem_en);
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(RPC + PW'(i));
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c == 0) begin
                rst = 1'b0; instr_ready = 1'b1;
            end
            @(negedge clk);
            if (c == 0) begin
                total++;
                if (imem_en !== 1'b1 || imem_addr !== RPC) begin
                    bad++;
                    $display("FAIL midreset_restart: got en=%b addr=%h, required en=1 addr=%h", imem_en, imem_addr, RPC);
                end
            end
        end
        tick();
        instr_ready = 1'b0;
        repeat (2) tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drained: got %0d undelivered words, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_branch();
        test_wrap();
        test_halt();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
